ram_arbiter: RTL and testbench

Shares the single-port data/instruction RAM between two requesters. Port 0 is the CPU (controller/counter fetch and load/store path). Port 1 is the memory loader/debug port used to fill or inspect RAM while the CPU runs or is halted. The block sits between the requesters and the RAM instance, drives the RAM address, write-enable and write-data, and returns registered read data with a valid strobe.

---
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: round-robin between
// the CPU port (0) and the loader/debug port (1), with a bounded burst lock for port 1.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic              last_served;
  logic              lock_active;
  logic [CNT_W-1:0]  lock_cnt;
  logic              sel0, sel1;
  logic              vld0_p1, vld1_p1;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (reset) begin
      if (lock_active && req1) begin
        sel1 = 1'b1;
      end else if (req0 && req1) begin
        sel0 = last_served;
        sel1 = ~last_served;
      end else begin
        sel0 = req0;
        sel1 = req1;
      end
    end
  end

  assign gnt0      = sel0;
  assign gnt1      = sel1;
  assign mem_addr  = sel1 ? addr1  : (sel0 ? addr0  : addr_p0);
  assign mem_wdata = sel1 ? wdata1 : (sel0 ? wdata0 : wdata_p0);
  assign mem_we    = (sel0 & we0) | (sel1 & we1);

  // The RAM presents data in the cycle after the grant; pass it straight through
  // while valid and keep the last returned word afterwards.
  assign rvalid0 = vld0_p1;
  assign rvalid1 = vld1_p1;
  assign rdata   = (vld0_p1 | vld1_p1) ? mem_rdata : rdata_p1;

  // Stage p0 -> p1: grant bookkeeping, lock tracking and read-return tagging
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_served <= 1'b1;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      vld0_p1     <= 1'b0;
      vld1_p1     <= 1'b0;
      addr_p0     <= '0;
      wdata_p0    <= '0;
      rdata_p1    <= '0;
    end else begin
      vld0_p1 <= sel0 & ~we0;
      vld1_p1 <= sel1 & ~we1;
      if (sel0 | sel1) begin
        last_served <= sel1;
        addr_p0     <= mem_addr;
        wdata_p0    <= mem_wdata;
      end
      if (vld0_p1 | vld1_p1) begin
        rdata_p1 <= mem_rdata;
      end
      if (sel1 && lock1) begin
        if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          lock_active <= 1'b0;
          lock_cnt    <= '0;
        end else begin
          lock_active <= 1'b1;
          lock_cnt    <= lock_cnt + 1'b1;
        end
      end else if (sel1 || !req1) begin
        lock_active <= 1'b0;
        lock_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration, lock and read-return rules.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;
  localparam int LOCK_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, we0, req1, we1, lock1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_we;

  logic [DATA_W-1:0] ram    [256];
  logic [DATA_W-1:0] shadow [256];

  int errors = 0;
  int checks = 0;

  // reference model state
  int                m_last;
  bit                m_lock;
  int                m_cnt;
  logic [ADDR_W-1:0] m_hold_addr;
  bit                exp_rv0, exp_rv1;
  logic [DATA_W-1:0] exp_rdata;
  int                last_g;
  int                seq [10];

  ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM: data appears the cycle after the address
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last      = 1;
    m_lock      = 1'b0;
    m_cnt       = 0;
    m_hold_addr = '0;
    exp_rv0     = 1'b0;
    exp_rv1     = 1'b0;
    last_g      = -1;
  endtask

  // One clock: predict and check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int g;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic w, r1, l1;
    @(negedge clk);
    g = -1;
    if (m_lock && req1)    g = 1;
    else if (req0 && req1) g = (m_last == 0) ? 1 : 0;
    else if (req0)         g = 0;
    else if (req1)         g = 1;
    a  = (g == 1) ? addr1  : addr0;
    w  = (g == 1) ? we1    : we0;
    d  = (g == 1) ? wdata1 : wdata0;
    r1 = req1;
    l1 = lock1;
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
    if (exp_rv0 || exp_rv1) chk("rdata", 32'(rdata), 32'(exp_rdata));
    if (g >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("mem_we", 32'(mem_we), 32'(w));
      if (w) chk("mem_wdata", 32'(mem_wdata), 32'(d));
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'(0));
      chk("mem_addr_hold", 32'(mem_addr), 32'(m_hold_addr));
    end
    @(posedge clk);
    exp_rv0 = (g == 0) && !w;
    exp_rv1 = (g == 1) && !w;
    if (g >= 0) begin
      m_last      = g;
      m_hold_addr = a;
      if (w) shadow[a] = d;
      else   exp_rdata = shadow[a];
    end
    if (g == 1 && l1) begin
      m_cnt++;
      if (m_cnt == LOCK_MAX) begin
        m_lock = 1'b0;
        m_cnt  = 0;
      end else begin
        m_lock = 1'b1;
      end
    end else if (g == 1 || !r1) begin
      m_lock = 1'b0;
      m_cnt  = 0;
    end
    last_g = g;
    #1;
  endtask

  task automatic rand_drive();
    if (last_g == 0 || !req0) begin
      if ($urandom_range(0, 3) != 0) begin
        req0 = 1'b1; addr0 = 8'($urandom_range(0, 15));
        we0 = 1'($urandom_range(0, 1)); wdata0 = 16'($urandom);
      end else req0 = 1'b0;
    end else if ($urandom_range(0, 15) == 0) req0 = 1'b0;
    if (last_g == 1 || !req1) begin
      if ($urandom_range(0, 3) != 0) begin
        req1 = 1'b1; addr1 = 8'($urandom_range(0, 15));
        we1 = 1'($urandom_range(0, 1)); wdata1 = 16'($urandom);
      end else req1 = 1'b0;
    end else if ($urandom_range(0, 15) == 0) req1 = 1'b0;
    lock1 = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'($urandom);
      shadow[i] = ram[i];
    end
    ram[8'h10] = 16'hBEEF; shadow[8'h10] = 16'hBEEF;
    ram[8'h20] = 16'h1234; shadow[8'h20] = 16'h1234;
    model_reset();

    // reset held with both ports requesting
    reset = 1'b0; lock1 = 1'b0;
    req0 = 1'b1; addr0 = 8'h10; we0 = 1'b0; wdata0 = '0;
    req1 = 1'b1; addr1 = 8'h20; we1 = 1'b0; wdata1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    @(posedge clk); #1 reset = 1'b1;

    // round-robin reads: 0,1,0,1... with data returned one cycle later
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_order", 32'(last_g), 32'(i % 2));
      if (last_g == 0) chk("rr_rdata0", 32'(rdata), 32'h0000BEEF);
      else             chk("rr_rdata1", 32'(rdata), 32'h00001234);
    end

    // port 1 writes, port 0 reads the same word back
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 8'h07; wdata1 = 16'hA5A5;
    step();
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h07;
    step();
    req0 = 1'b0;
    step();
    chk("wr_rd_rdata", 32'(rdata), 32'h0000A5A5);

    // locked burst from port 1 against a constantly requesting port 0
    req0 = 1'b1; addr0 = 8'h10; we0 = 1'b0;
    req1 = 1'b1; addr1 = 8'h20; we1 = 1'b0; lock1 = 1'b1;
    seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      step();
      chk("lock_seq", 32'(last_g), 32'(seq[i]));
    end

    // break a burst by dropping both requests for a cycle
    step(); step();
    req0 = 1'b0; req1 = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("lock_release", 32'(last_g), 32'(0));

    // reset arrives while a read is in flight
    req1 = 1'b0; lock1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    @(negedge clk);
    chk("midrd_gnt0", 32'(gnt0), 1);
    #2 reset = 1'b0;
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("midrd_rvalid0", 32'(rvalid0), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step();
    chk("midrd_rdata", 32'(rdata), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
